// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO multiply-divide unit for the EX stage.
// Owns the HI and LO registers. mult/multu/madd/msub/mthi/mtlo finish in
// one cycle; div/divu run a WIDTH-iteration restoring divider.
// Optional feature macro: HILO_DIV_EN. When it is undefined there is no
// divider: div/divu act as nop, Busy and DivZero are tied low.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_MADD  = 4'b0011;
  localparam logic [3:0] OP_MSUB  = 4'b0100;
  localparam logic [3:0] OP_DIV   = 4'b0110;
  localparam logic [3:0] OP_DIVU  = 4'b0111;
  localparam logic [3:0] OP_MTHI  = 4'b1000;
  localparam logic [3:0] OP_MTLO  = 4'b1001;

  // Architectural state
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  // Full-width products: sign/zero extend first so the 2*WIDTH-bit
  // multiply yields the exact product in its low 2*WIDTH bits.
  logic [2*WIDTH-1:0] w_a_sext;
  logic [2*WIDTH-1:0] w_b_sext;
  logic [2*WIDTH-1:0] w_a_zext;
  logic [2*WIDTH-1:0] w_b_zext;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic [2*WIDTH-1:0] w_hilo;

  assign w_a_sext = {{WIDTH{A[WIDTH-1]}}, A};
  assign w_b_sext = {{WIDTH{B[WIDTH-1]}}, B};
  assign w_a_zext = {{WIDTH{1'b0}}, A};
  assign w_b_zext = {{WIDTH{1'b0}}, B};
  assign w_prod_s = w_a_sext * w_b_sext;
  assign w_prod_u = w_a_zext * w_b_zext;
  assign w_hilo   = {r_hi, r_lo};

`ifdef HILO_DIV_EN
  typedef enum logic {S_IDLE, S_DIV} state_t;

  localparam int               CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic             r_divzero;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;      // partial remainder
  logic [WIDTH-1:0] r_quo;      // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] r_divisor;  // divisor magnitude
  logic             r_neg_q;    // negate quotient at the end
  logic             r_neg_r;    // negate remainder at the end

  // Operand magnitudes at acceptance; most-negative maps onto 2^(WIDTH-1),
  // which is the correct unsigned magnitude.
  logic             w_signed_div;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_signed_div = (Op == OP_DIV);
  assign w_a_mag = (w_signed_div && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign w_b_mag = (w_signed_div && B[WIDTH-1]) ? (~B + 1'b1) : B;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The remainder is always below the divisor, so the shifted value is below
  // twice the divisor and the difference fits in WIDTH bits.
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_trial;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;

  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_divisor});
  assign w_trial    = w_shift[WIDTH-1:0] - r_divisor;
  assign w_rem_next = w_ge ? w_trial : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};
  assign w_q_final  = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
  assign w_r_final  = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

  // Control FSM, HI/LO update and divider iteration
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_done <= 1'b1;
            case (Op)
              OP_MULT:  {r_hi, r_lo} <= w_prod_s;
              OP_MULTU: {r_hi, r_lo} <= w_prod_u;
              OP_MADD:  {r_hi, r_lo} <= w_hilo + w_prod_s;
              OP_MSUB:  {r_hi, r_lo} <= w_hilo - w_prod_s;
              OP_MTHI:  r_hi <= A;
              OP_MTLO:  r_lo <= A;
              OP_DIV, OP_DIVU: begin
                if (B == '0) begin
                  // No iterations; HI/LO untouched, flag with Done.
                  r_divzero <= 1'b1;
                end else begin
                  r_done    <= 1'b0;
                  r_state   <= S_DIV;
                  r_count   <= '0;
                  r_rem     <= '0;
                  r_quo     <= w_a_mag;
                  r_divisor <= w_b_mag;
                  r_neg_q   <= w_signed_div && (A[WIDTH-1] ^ B[WIDTH-1]);
                  r_neg_r   <= w_signed_div && A[WIDTH-1];
                end
              end
              OP_NOP:   ;
              default:  ;
            endcase
          end
        end
        S_DIV: begin
          r_rem   <= w_rem_next;
          r_quo   <= w_quo_next;
          r_count <= r_count + 1'b1;
          if (r_count == LAST) begin
            // Sign correction folded into the last step; HI/LO change only here.
            r_hi    <= w_r_final;
            r_lo    <= w_q_final;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy    = (r_state == S_DIV);
  assign DivZero = r_divzero;
`else
  // Single-cycle HI/LO operations; div/divu complete as nop
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= Start;
      if (Start) begin
        case (Op)
          OP_MULT:  {r_hi, r_lo} <= w_prod_s;
          OP_MULTU: {r_hi, r_lo} <= w_prod_u;
          OP_MADD:  {r_hi, r_lo} <= w_hilo + w_prod_s;
          OP_MSUB:  {r_hi, r_lo} <= w_hilo - w_prod_s;
          OP_MTHI:  r_hi <= A;
          OP_MTLO:  r_lo <= A;
          OP_NOP, OP_DIV, OP_DIVU: ;
          default:  ;
        endcase
      end
    end
  end

  assign Busy    = 1'b0;
  assign DivZero = 1'b0;
`endif

  assign Hi   = r_hi;
  assign Lo   = r_lo;
  assign Done = r_done;

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised HI/LO multiply-divide unit for the EX stage of the MIPS pipeline, and the sequential successor to the combinational ALU control's HiLoWrite path. It owns the HI and LO registers and executes mult, multu, madd, msub, mthi, mtlo in one cycle, and div/divu as a WIDTH-cycle restoring divider. During a divide it drives Busy so the hazard unit can stall mfhi/mflo and further HI/LO operations.

## Interface
- WIDTH, 32: operand and HI/LO register width; must be at least 4.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  operation request; sampled only when Busy=0.
- Op  in  4  operation: 0000 nop, 0001 mult, 0010 multu, 0011 madd, 0100 msub, 0110 div, 0111 divu, 1000 mthi, 1001 mtlo; all other codes act as nop.
- A  in  WIDTH  rs operand (dividend, multiplicand, mthi/mtlo source).
- B  in  WIDTH  rt operand (divisor, multiplier).
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.
- Busy  out  1  divide in progress.
- Done  out  1  one-cycle completion pulse.
- DivZero  out  1  one-cycle pulse, coincident with Done, when a divide had B=0.

## Operation
- FSM states:
  - IDLE → DIV when Start=1 is accepted with div/divu and B≠0.
  - DIV → IDLE after WIDTH iterations.
  - All other accepted ops complete in IDLE.
- mult: {Hi,Lo} ← signed A × signed B, full 2·WIDTH-bit product.
- multu: {Hi,Lo} ← unsigned A × unsigned B.
- madd: {Hi,Lo} ← {Hi,Lo} + signed A×B, modulo 2^(2·WIDTH).
- msub: {Hi,Lo} ← {Hi,Lo} − signed A×B, modulo 2^(2·WIDTH).
- mthi: Hi ← A, Lo unchanged. mtlo: Lo ← A, Hi unchanged.
- div: operates on operand magnitudes, then applies sign correction in the final iteration.
  - Lo ← quotient, truncated toward zero.
  - Hi ← remainder, with the sign of the dividend.
- divu: Lo ← unsigned quotient, Hi ← unsigned remainder.
- Overflow case: div of most-negative by −1 gives Lo = most-negative and Hi = 0.
- Divide by zero (div or divu with B=0): no DIV state; Hi and Lo unchanged; DivZero=1 with Done.
- Operands are latched at acceptance. A and B may change during DIV.
- Start while Busy=1 is ignored: not queued, and Done is not generated for it.
- nop and undefined Op with Start=1: Done pulses; no state change.

## Timing
- Reset asserted: Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, FSM=IDLE, immediately (asynchronous). This aborts any divide in flight.
- Single-cycle ops accepted at edge E0:
  - Hi/Lo are updated at E0.
  - Done=1 for the cycle following E0.
  - Busy stays 0, so back-to-back ops are accepted every cycle.
- Divide accepted at edge E0:
  - Busy=1 from E0 through edge E_WIDTH, one iteration per edge E1..E_WIDTH.
  - Hi/Lo are written at E_WIDTH; Busy falls at E_WIDTH.
  - Done=1 for the cycle following E_WIDTH.
  - Total latency is WIDTH+1 edges from acceptance to Done.
- A Start that coincides with the cycle Busy falls, i.e. sampled at E_WIDTH, is ignored. The next accept is at E_WIDTH+1.
- Hi/Lo hold their old values throughout DIV; there are no intermediate updates.

## Configuration
- Macro HILO_DIV_EN:
  - Defined: divider datapath and DIV state are present, as described above.
  - Undefined: no divider hardware. div/divu behave as nop (Done pulses, Hi/Lo unchanged), Busy is tied to 0, and DivZero is tied to 0.

## Test plan
- Reset, then mthi 0x12345678 and mtlo 0x9ABCDEF0 → Hi=0x12345678, Lo=0x9ABCDEF0, one Done pulse each, Busy=0. Assert Reset → Hi=Lo=0 without a clock edge.
- mult A=0xFFFFFFFD, B=7 → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. multu with the same operands → Hi=0x00000006, Lo=0xFFFFFFEB.
- mthi 0, mtlo 0xFFFFFFFF, then madd A=1, B=1 → Hi=1, Lo=0 (carry across LO). Then msub A=1, B=1 → Hi=0, Lo=0xFFFFFFFF.
- div A=0xFFFFFFF9 (−7), B=2 → Busy high for exactly 32 cycles; Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; Done one cycle later. A Start mult issued at cycle 5 of the divide is ignored. divu 100/7 → Lo=14, Hi=2.
- div A=5, B=0 → Done and DivZero pulse the next cycle, Busy never asserts, Hi/Lo unchanged. div A=0x80000000, B=0xFFFFFFFF → Lo=0x80000000, Hi=0.
- Reset during iteration 10 of a divide → Busy=0, Hi=Lo=0, no Done. A subsequent multu 3×5 → Lo=15, Hi=0.
